// File: rtl/gpu_axis_pkg.sv
// Shared types for the AXI-Stream memory writer: FSM state encoding and width helpers.
package gpu_axis_pkg;

    localparam int STATE_W    = 2;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_KEEP_W = DEF_DATA_W / 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int keep_w_of(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/gpu_axis_addr_gen.sv
// Word address generator: loads the base, steps with silent wrap at 2^ADDR_W,
// and keeps a word counter that saturates at the programmed limit.
module gpu_axis_addr_gen #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_step,
    input  logic [CNT_W-1:0]  i_limit,
    output logic [ADDR_W-1:0] o_addr,
    output logic [CNT_W-1:0]  o_count
);

    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_addr  <= i_base;
            r_count <= '0;
        end else if (i_step) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_count != i_limit) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_addr  = r_addr;
    assign o_count = r_count;

endmodule

// File: rtl/gpu_axis_mem_writer.sv
// AXI-Stream packet ingest into data memory with per-packet word limit and drain.
// Optional GPU_AXIS_TKEEP_EN: byte enables follow tkeep instead of all ones.
module gpu_axis_mem_writer
    import gpu_axis_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 12,
    localparam int KEEP_W = keep_w_of(DATA_W),
    localparam int CNT_W  = ADDR_W + 1
) (
    input  logic               gpu_clk,
    input  logic               reset,
    input  logic               cfg_start,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    input  logic [CNT_W-1:0]   cfg_max_words,
    input  logic [DATA_W-1:0]  axis_tdata,
    input  logic [KEEP_W-1:0]  axis_tkeep,
    input  logic               axis_tlast,
    input  logic               axis_tvalid,
    output logic               axis_tready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wr_data,
    output logic [KEEP_W-1:0]  mem_wr_en,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [CNT_W-1:0]   word_count,
    output logic [STATE_W-1:0] dbg_state
);

    // Handshake: a beat transfers on a rising edge where axis_tvalid && axis_tready;
    // tready depends only on state, so it never combinationally follows tvalid.
    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_max_words;
    logic              r_overflow;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wr_data;
    logic [KEEP_W-1:0] r_mem_wr_en;
    logic [KEEP_W-1:0] w_beat_en;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [CNT_W-1:0]  w_word_count;
    logic              w_start_ok, w_beat, w_write, w_at_limit, w_set_ovf;

    assign w_start_ok  = cfg_start && (r_state == IDLE);
    assign axis_tready = (r_state == RECV) || (r_state == DRAIN);
    assign w_beat      = axis_tvalid && axis_tready;
    assign w_write     = w_beat && (r_state == RECV);
    assign w_at_limit  = (w_word_count + CNT_W'(1)) == r_max_words;

`ifdef GPU_AXIS_TKEEP_EN
    assign w_beat_en = axis_tkeep;
`else
    logic w_unused_tkeep;
    assign w_unused_tkeep = ^axis_tkeep;
    assign w_beat_en      = {KEEP_W{1'b1}};
`endif

    always_comb begin
        w_next    = r_state;
        w_set_ovf = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_next = (cfg_max_words == '0) ? DRAIN : RECV;
                end
            end
            RECV: begin
                // tlast wins over the limit: a limit-hitting last beat is a clean finish
                if (w_beat) begin
                    if (axis_tlast) begin
                        w_next = DONE;
                    end else if (w_at_limit) begin
                        w_next    = DRAIN;
                        w_set_ovf = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (w_beat && axis_tlast) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge gpu_clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_max_words <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_max_words <= cfg_max_words;
                r_overflow  <= (cfg_max_words == '0);
            end else if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Registered write port: byte enables are live only in the cycle after acceptance
    always_ff @(posedge gpu_clk) begin
        if (reset) begin
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_mem_wr_en   <= '0;
        end else begin
            r_mem_wr_en <= w_write ? w_beat_en : '0;
            if (w_write) begin
                r_mem_addr    <= w_cur_addr;
                r_mem_wr_data <= axis_tdata;
            end
        end
    end

    gpu_axis_addr_gen #(
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) u_addr_gen (
        .clk    (gpu_clk),
        .reset  (reset),
        .i_load (w_start_ok),
        .i_base (cfg_base_addr),
        .i_step (w_write),
        .i_limit(r_max_words),
        .o_addr (w_cur_addr),
        .o_count(w_word_count)
    );

    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign mem_wr_en   = r_mem_wr_en;
    assign busy        = axis_tready;
    assign done        = (r_state == DONE);
    assign overflow    = r_overflow;
    assign word_count  = w_word_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_gpu_axis_mem_writer.sv
// Directed bench for gpu_axis_mem_writer: expected writes queued by the driver,
// popped and compared by a monitor whenever mem_wr_en is nonzero.
module tb_gpu_axis_mem_writer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;
    localparam int KEEP_W = 4;
    localparam int CNT_W  = 13;
    localparam int REC_W  = ADDR_W + DATA_W + KEEP_W;

    logic              gpu_clk;
    logic              reset;
    logic              cfg_start;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [CNT_W-1:0]  cfg_max_words;
    logic [DATA_W-1:0] axis_tdata;
    logic [KEEP_W-1:0] axis_tkeep;
    logic              axis_tlast;
    logic              axis_tvalid;
    logic              axis_tready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [KEEP_W-1:0] mem_wr_en;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [CNT_W-1:0]  word_count;
    logic [1:0]        dbg_state;

    int n_checks  = 0;
    int n_pass    = 0;
    int done_seen = 0;
    int exp_done  = 0;
    logic [REC_W-1:0] exp_q[$];

    gpu_axis_mem_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .gpu_clk      (gpu_clk),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .cfg_base_addr(cfg_base_addr),
        .cfg_max_words(cfg_max_words),
        .axis_tdata   (axis_tdata),
        .axis_tkeep   (axis_tkeep),
        .axis_tlast   (axis_tlast),
        .axis_tvalid  (axis_tvalid),
        .axis_tready  (axis_tready),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .word_count   (word_count),
        .dbg_state    (dbg_state)
    );

    // clock / watchdog
    initial gpu_clk = 1'b0;
    always #5 gpu_clk = ~gpu_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal end");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic logic [KEEP_W-1:0] exp_en(input logic [KEEP_W-1:0] k);
`ifdef GPU_AXIS_TKEEP_EN
        return k;
`else
        return (k == k) ? 4'hF : 4'hF;
`endif
    endfunction

    // scoreboard monitor
    always @(negedge gpu_clk) begin
        if (done === 1'b1) done_seen++;
        if (mem_wr_en !== '0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h en 0x%0h, required no write",
                         mem_addr, mem_wr_data, mem_wr_en);
            end else begin
                check("mem_write", 64'({mem_addr, mem_wr_data, mem_wr_en}), 64'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic start_pkt(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] maxw);
        @(negedge gpu_clk);
        cfg_start     = 1'b1;
        cfg_base_addr = base;
        cfg_max_words = maxw;
        @(negedge gpu_clk);
        cfg_start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic last, input logic [KEEP_W-1:0] keep,
                             input logic wr, input logic [ADDR_W-1:0] addr);
        int t;
        t = 0;
        @(negedge gpu_clk);
        cfg_start   = 1'b0;
        axis_tdata  = d;
        axis_tkeep  = keep;
        axis_tlast  = last;
        axis_tvalid = 1'b1;
        while (axis_tready !== 1'b1 && t < 20) begin
            @(negedge gpu_clk);
            t++;
        end
        if (axis_tready !== 1'b1) begin
            n_checks++;
            $display("FAIL beat_timeout: tready %b after 20 cycles, required 1", axis_tready);
            axis_tvalid = 1'b0;
        end else if (wr && exp_en(keep) != '0) begin
            exp_q.push_back({addr, d, exp_en(keep)});
        end
        @(posedge gpu_clk);
    endtask

    task automatic finish_pkt(input int exp_wc, input logic exp_ovf);
        int t;
        t = 0;
        @(negedge gpu_clk);
        axis_tvalid = 1'b0;
        axis_tlast  = 1'b0;
        while (done !== 1'b1 && t < 20) begin
            @(negedge gpu_clk);
            t++;
        end
        exp_done++;
        check("done_pulse", done, 1'b1);
        check("word_count", word_count, exp_wc);
        check("overflow", overflow, exp_ovf);
        @(negedge gpu_clk);
        check("after_done_idle", {done, busy, axis_tready}, 3'b000);
    endtask

    initial begin
        reset         = 1'b1;
        cfg_start     = 1'b0;
        cfg_base_addr = '0;
        cfg_max_words = '0;
        axis_tdata    = '0;
        axis_tkeep    = '0;
        axis_tlast    = 1'b0;
        axis_tvalid   = 1'b0;
        repeat (3) @(posedge gpu_clk);
        @(negedge gpu_clk);
        check("rst_tready", axis_tready, 1'b0);
        check("rst_outputs", {busy, done, overflow, mem_wr_en}, '0);
        check("rst_word_count", word_count, '0);
        check("rst_mem_addr_data", {mem_addr, mem_wr_data}, '0);
        check("rst_state", dbg_state, 2'd0);
        reset = 1'b0;

        // T1: exact-limit packet, clean finish
        start_pkt(12'h010, 13'd4);
        for (int i = 0; i < 4; i++)
            send_beat(32'hA0 + i, i == 3, 4'hF, 1'b1, 12'h010 + 12'(i));
        finish_pkt(4, 1'b0);

        // T2: oversize packet drains after two writes
        start_pkt(12'h020, 13'd2);
        for (int i = 0; i < 5; i++)
            send_beat(32'hB0 + i, i == 4, 4'hF, i < 2, 12'h020 + 12'(i));
        finish_pkt(2, 1'b1);

        // T3: address wrap FFE, FFF, 000, 001
        start_pkt(12'hFFE, 13'd4);
        send_beat(32'hC0, 1'b0, 4'hF, 1'b1, 12'hFFE);
        send_beat(32'hC1, 1'b0, 4'hF, 1'b1, 12'hFFF);
        send_beat(32'hC2, 1'b0, 4'hF, 1'b1, 12'h000);
        send_beat(32'hC3, 1'b1, 4'hF, 1'b1, 12'h001);
        finish_pkt(4, 1'b0);

        // T4: tvalid gaps plus an ignored cfg_start mid-packet
        start_pkt(12'h100, 13'd8);
        for (int i = 0; i < 4; i++) begin
            send_beat(32'hD0 + i, i == 3, 4'hF, 1'b1, 12'h100 + 12'(i));
            if (i < 3) begin
                @(negedge gpu_clk);
                axis_tvalid = 1'b0;
                if (i == 1) begin
                    cfg_start     = 1'b1;
                    cfg_base_addr = 12'h300;
                    cfg_max_words = 13'd1;
                end
                check("gap_hold_count", word_count, i + 1);
            end
        end
        finish_pkt(4, 1'b0);

        // zero limit: drain only
        start_pkt(12'h050, 13'd0);
        check("zero_limit_ovf", overflow, 1'b1);
        send_beat(32'h51, 1'b0, 4'hF, 1'b0, 12'h000);
        send_beat(32'h52, 1'b1, 4'hF, 1'b0, 12'h000);
        finish_pkt(0, 1'b1);

        // T5: reset after beat 2 of a 6-beat packet
        start_pkt(12'h040, 13'd8);
        send_beat(32'hE0, 1'b0, 4'hF, 1'b1, 12'h040);
        send_beat(32'hE1, 1'b0, 4'hF, 1'b1, 12'h041);
        @(negedge gpu_clk);
        check("pre_reset_count", word_count, 13'd2);
        axis_tdata  = 32'hE2;
        axis_tlast  = 1'b0;
        axis_tvalid = 1'b1;
        reset       = 1'b1;
        @(negedge gpu_clk);
        reset = 1'b0;
        check("mid_rst_wr_en", mem_wr_en, 4'h0);
        check("mid_rst_status", {busy, overflow, axis_tready}, 3'b000);
        check("mid_rst_count", word_count, '0);
        repeat (3) begin
            @(negedge gpu_clk);
            check("stalled_tready", axis_tready, 1'b0);
        end
        axis_tvalid = 1'b0;

        // recovery packet after the interrupted one
        start_pkt(12'h060, 13'd3);
        for (int i = 0; i < 3; i++)
            send_beat(32'h60 + i, i == 2, 4'hF, 1'b1, 12'h060 + 12'(i));
        finish_pkt(3, 1'b0);

        // T6: partial then empty byte enables (all ones when tkeep is ignored)
        start_pkt(12'h070, 13'd2);
        send_beat(32'hF0, 1'b0, 4'b0101, 1'b1, 12'h070);
        send_beat(32'hF1, 1'b1, 4'b0000, 1'b1, 12'h071);
        finish_pkt(2, 1'b0);

        @(negedge gpu_clk);
        check("done_count", done_seen, exp_done);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
